// File: rtl/vga_fb_display_if.sv
// Draw/fill request bus between the processor side and the framebuffer display.
interface vga_fb_display_if #(
    parameter int CH_BITS = 3
);
    logic                   Draw_Valid;
    logic                   Draw_Ready;
    logic [15:0]            Draw_X;
    logic [15:0]            Draw_Y;
    logic [3*CH_BITS-1:0]   Draw_Color;
    logic                   Fill_Start;
    logic [3*CH_BITS-1:0]   Fill_Color;
    logic                   Fill_Busy;

    modport master (
        output Draw_Valid, Draw_X, Draw_Y, Draw_Color, Fill_Start, Fill_Color,
        input  Draw_Ready, Fill_Busy
    );

    modport slave (
        input  Draw_Valid, Draw_X, Draw_Y, Draw_Color, Fill_Start, Fill_Color,
        output Draw_Ready, Fill_Busy
    );
endinterface

// File: rtl/vga_fb_display.sv
// VGA framebuffer display: raster timing, dual-port framebuffer with a
// draw/fill write engine, and a two-pixel-tick colour output pipeline.
module vga_fb_display #(
    parameter int FB_WIDTH      = 160,
    parameter int FB_HEIGHT     = 120,
    parameter int FB_SCALE_LOG2 = 2,
    parameter int CH_BITS       = 3,
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33
) (
    input  logic              Fast_Clock,
    input  logic              Reset_N,
    vga_fb_display_if.slave   draw,
    output logic              Frame_Start,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_Clk,
    output logic [7:0]        VGA_Red,
    output logic [7:0]        VGA_Green,
    output logic [7:0]        VGA_Blue,
    output logic              VGA_Blank_N,
    output logic              VGA_Sync_N
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DEPTH   = FB_WIDTH * FB_HEIGHT;
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WORD_W  = 3 * CH_BITS;
    localparam int HC_W    = $clog2(H_TOTAL);
    localparam int VC_W    = $clog2(V_TOTAL);

    typedef enum logic {IDLE, FILL} state_t;

    // Raster timing
    logic            pix_en;
    logic [HC_W-1:0] h_count;
    logic [VC_W-1:0] v_count;
    logic            hs_raw, vs_raw, act_raw;
    logic [31:0]     rd_full;

    // Output pipeline
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [WORD_W-1:0] rd_data_reg;
    logic              hs_d1, vs_d1, act_d1;
    logic              hs_d2, vs_d2, act_d2;
    logic [7:0]        red_x, green_x, blue_x;

    // Framebuffer and write engine
    logic [WORD_W-1:0] ram [DEPTH];
    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] fill_addr_reg, fill_addr_next;
    logic [WORD_W-1:0] fill_color_reg, fill_color_next;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              draw_in_range;
    logic              ready, busy;

    // Pixel tick: half-rate enable, also forwarded as the DAC pixel clock
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) pix_en <= 1'b0;
        else          pix_en <= ~pix_en;
    end

    // Horizontal/vertical raster counters
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_en) begin
            if (h_count == HC_W'(H_TOTAL - 1)) begin
                h_count <= '0;
                v_count <= (v_count == VC_W'(V_TOTAL - 1)) ? '0 : v_count + 1'b1;
            end else begin
                h_count <= h_count + 1'b1;
            end
        end
    end

    assign hs_raw  = !((32'(h_count) >= 32'(H_ACTIVE + H_FRONT)) &&
                       (32'(h_count) <  32'(H_ACTIVE + H_FRONT + H_SYNC)));
    assign vs_raw  = !((32'(v_count) >= 32'(V_ACTIVE + V_FRONT)) &&
                       (32'(v_count) <  32'(V_ACTIVE + V_FRONT + V_SYNC)));
    assign act_raw = (32'(h_count) < 32'(H_ACTIVE)) && (32'(v_count) < 32'(V_ACTIVE));
    assign rd_full = ((32'(v_count) >> FB_SCALE_LOG2) * 32'(FB_WIDTH)) +
                     (32'(h_count) >> FB_SCALE_LOG2);

    // Stage 1: register read address and raw sync/blank. Addresses past the
    // end of the buffer only occur in blanking, so they fold to 0.
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            rd_addr_reg <= '0;
            hs_d1       <= 1'b1;
            vs_d1       <= 1'b1;
            act_d1      <= 1'b0;
        end else if (pix_en) begin
            rd_addr_reg <= (rd_full < 32'(DEPTH)) ? ADDR_W'(rd_full) : '0;
            hs_d1       <= hs_raw;
            vs_d1       <= vs_raw;
            act_d1      <= act_raw;
        end
    end

    // Stage 2: synchronous framebuffer read (no reset so it maps to block RAM)
    always_ff @(posedge Fast_Clock) begin
        if (pix_en) rd_data_reg <= ram[rd_addr_reg];
    end

    // Stage 2: sync/blank delayed to line up with the read data
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            hs_d2  <= 1'b1;
            vs_d2  <= 1'b1;
            act_d2 <= 1'b0;
        end else if (pix_en) begin
            hs_d2  <= hs_d1;
            vs_d2  <= vs_d1;
            act_d2 <= act_d1;
        end
    end

    // Bit-replicate each stored channel MSB-first to fill 8 DAC bits
    for (genvar gi = 0; gi < 8; gi++) begin : g_expand
        assign red_x[7-gi]   = rd_data_reg[3*CH_BITS - 1 - (gi % CH_BITS)];
        assign green_x[7-gi] = rd_data_reg[2*CH_BITS - 1 - (gi % CH_BITS)];
        assign blue_x[7-gi]  = rd_data_reg[CH_BITS - 1 - (gi % CH_BITS)];
    end

    assign VGA_Red     = act_d2 ? red_x   : 8'd0;
    assign VGA_Green   = act_d2 ? green_x : 8'd0;
    assign VGA_Blue    = act_d2 ? blue_x  : 8'd0;
    assign VGA_Blank_N = act_d2;
    assign VGA_HS      = hs_d2;
    assign VGA_VS      = vs_d2;
    assign VGA_Sync_N  = 1'b0;
    assign VGA_Clk     = pix_en;
    assign Frame_Start = pix_en && (h_count == '0) && (v_count == '0);

    // Framebuffer write port
    always_ff @(posedge Fast_Clock) begin
        if (wr_en) ram[wr_addr] <= wr_data;
    end

    // Write engine state registers
    always_ff @(posedge Fast_Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg      <= IDLE;
            fill_addr_reg  <= '0;
            fill_color_reg <= '0;
        end else begin
            state_reg      <= state_next;
            fill_addr_reg  <= fill_addr_next;
            fill_color_reg <= fill_color_next;
        end
    end

    assign draw_in_range = (32'(draw.Draw_X) < 32'(FB_WIDTH)) &&
                           (32'(draw.Draw_Y) < 32'(FB_HEIGHT));

    // Write engine next state: draws in IDLE (out-of-range ones are
    // acknowledged but dropped), one fill word per cycle in FILL
    always_comb begin
        state_next      = state_reg;
        fill_addr_next  = fill_addr_reg;
        fill_color_next = fill_color_reg;
        wr_en           = 1'b0;
        wr_addr         = ADDR_W'(32'(draw.Draw_Y) * 32'(FB_WIDTH) + 32'(draw.Draw_X));
        wr_data         = draw.Draw_Color;
        ready           = 1'b0;
        busy            = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (draw.Draw_Valid && draw_in_range) wr_en = 1'b1;
                if (draw.Fill_Start) begin
                    fill_color_next = draw.Fill_Color;
                    fill_addr_next  = '0;
                    state_next      = FILL;
                end
            end
            FILL: begin
                busy    = 1'b1;
                wr_en   = 1'b1;
                wr_addr = fill_addr_reg;
                wr_data = fill_color_reg;
                if (fill_addr_reg == ADDR_W'(DEPTH - 1)) state_next = IDLE;
                else                                      fill_addr_next = fill_addr_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    assign draw.Draw_Ready = ready;
    assign draw.Fill_Busy  = busy;
endmodule

// File: tb/tb_vga_fb_display.sv
// Directed bench for vga_fb_display on a reduced geometry (16x8 framebuffer,
// scale 4, 80x38 raster) so whole frames fit in a short run.
module tb_vga_fb_display;
    localparam int FBW = 16, FBH = 8, SC = 2;
    localparam int HT = 80, VT = 38;           // 64+4+8+4, 32+2+2+2
    localparam int FRAME_CYC = 2 * HT * VT;    // 6080 Fast_Clock cycles
    localparam int DEPTH = FBW * FBH;          // 128 words

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       frame_start, hs, vs, vclk, blank_n, sync_n;
    logic [7:0] red, green, blue;

    vga_fb_display_if #(.CH_BITS(3)) dif ();

    vga_fb_display #(
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .FB_SCALE_LOG2(SC), .CH_BITS(3),
        .H_ACTIVE(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
        .V_ACTIVE(32), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
    ) dut (
        .Fast_Clock(clk), .Reset_N(rst_n), .draw(dif),
        .Frame_Start(frame_start), .VGA_HS(hs), .VGA_VS(vs), .VGA_Clk(vclk),
        .VGA_Red(red), .VGA_Green(green), .VGA_Blue(blue),
        .VGA_Blank_N(blank_n), .VGA_Sync_N(sync_n)
    );

    int n_assert = 0;
    int n_fail = 0;
    logic [8:0] fb_model [DEPTH];

    // Captured screen pixels {R,G,B} from the latest frame scan
    logic [23:0] p_20_12, p_23_15, p_24_12, p_27_15, p_19_12, p_28_12, p_4_12, p_8_12;

    function automatic logic [7:0] exp8(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic draw_px(input int x, input int y, input logic [8:0] col, input string tag);
        @(negedge clk);
        dif.Draw_Valid = 1'b1;
        dif.Draw_X     = 16'(x);
        dif.Draw_Y     = 16'(y);
        dif.Draw_Color = col;
        check({tag, "_ready"}, 32'(dif.Draw_Ready), 32'd1);
        @(negedge clk);
        dif.Draw_Valid = 1'b0;
        if (x < FBW && y < FBH) fb_model[y*FBW + x] = col;
    endtask

    // Walk one whole frame from Frame_Start, comparing every pixel's sync,
    // blank and colour against the model, and tallying timing statistics.
    task automatic scan_frame(input string tag);
        int found = 0;
        int fs_next = -1;
        int hs_low = 0, vs_low = 0, blank_hi = 0;
        int pix_err = 0, clk_err = 0;
        int k, h, v;
        logic exp_hs, exp_vs, exp_act;
        logic [8:0] w;
        logic [23:0] exp_rgb, rgb;
        for (int i = 0; i < FRAME_CYC + 10; i++) begin
            @(negedge clk);
            if (frame_start) begin
                found = 1;
                break;
            end
        end
        check({tag, "_fs_found"}, 32'(found), 32'd1);
        if (found == 0) return;
        for (int n = 1; n <= FRAME_CYC + 3; n++) begin
            @(negedge clk);
            if (frame_start && fs_next < 0) fs_next = n;
            if (vclk !== ((n % 2) == 0)) clk_err++;
            if (n >= 3 && n < 3 + FRAME_CYC) begin
                if (!hs) hs_low++;
                if (!vs) vs_low++;
                if (blank_n) blank_hi++;
                if ((n % 2) == 1) begin
                    k = (n - 3) / 2;
                    h = k % HT;
                    v = k / HT;
                    exp_hs  = !(h >= 68 && h < 76);
                    exp_vs  = !(v >= 34 && v < 36);
                    exp_act = (h < 64) && (v < 32);
                    exp_rgb = 24'd0;
                    if (exp_act) begin
                        w = fb_model[(v / 4) * FBW + (h / 4)];
                        exp_rgb = {exp8(w[8:6]), exp8(w[5:3]), exp8(w[2:0])};
                    end
                    rgb = {red, green, blue};
                    if (hs !== exp_hs || vs !== exp_vs || blank_n !== exp_act ||
                        rgb !== exp_rgb || sync_n !== 1'b0) pix_err++;
                    if (v == 12 && h == 20) p_20_12 = rgb;
                    if (v == 15 && h == 23) p_23_15 = rgb;
                    if (v == 12 && h == 24) p_24_12 = rgb;
                    if (v == 15 && h == 27) p_27_15 = rgb;
                    if (v == 12 && h == 19) p_19_12 = rgb;
                    if (v == 12 && h == 28) p_28_12 = rgb;
                    if (v == 12 && h == 4)  p_4_12  = rgb;
                    if (v == 12 && h == 8)  p_8_12  = rgb;
                end
            end
        end
        check({tag, "_pixel_errors"}, 32'(pix_err), 32'd0);
        check({tag, "_vga_clk_errors"}, 32'(clk_err), 32'd0);
        check({tag, "_hs_low_cycles"}, 32'(hs_low), 32'd608);     // 38 lines * 16
        check({tag, "_vs_low_cycles"}, 32'(vs_low), 32'd320);     // 2 lines * 160
        check({tag, "_blank_hi_cycles"}, 32'(blank_hi), 32'd4096); // 64*32*2
        check({tag, "_frame_period"}, 32'(fs_next), 32'(FRAME_CYC));
    endtask

    initial begin
        int busy_cnt, rdy_low, guard;
        dif.Draw_Valid = 1'b0;
        dif.Draw_X     = '0;
        dif.Draw_Y     = '0;
        dif.Draw_Color = '0;
        dif.Fill_Start = 1'b0;
        dif.Fill_Color = '0;

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check("rst_hs", 32'(hs), 32'd1);
        check("rst_vs", 32'(vs), 32'd1);
        check("rst_blank_n", 32'(blank_n), 32'd0);
        check("rst_rgb", 32'({red, green, blue}), 32'd0);
        check("rst_fill_busy", 32'(dif.Fill_Busy), 32'd0);
        check("rst_frame_start", 32'(frame_start), 32'd0);
        check("rst_vga_clk", 32'(vclk), 32'd0);
        check("rst_sync_n", 32'(sync_n), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(dif.Draw_Ready), 32'd1);

        // Fill with black; a draw becomes pending while the fill runs and a
        // second Fill_Start mid-fill must be ignored
        dif.Fill_Color = 9'h000;
        dif.Fill_Start = 1'b1;
        @(negedge clk);
        dif.Fill_Start = 1'b0;
        check("fill_busy_first", 32'(dif.Fill_Busy), 32'd1);
        dif.Draw_Valid = 1'b1;
        dif.Draw_X     = 16'd5;
        dif.Draw_Y     = 16'd3;
        dif.Draw_Color = 9'h1FF;
        busy_cnt = 1;
        rdy_low  = (dif.Draw_Ready == 1'b0) ? 1 : 0;
        guard    = 0;
        while (guard < 1000) begin
            @(negedge clk);
            guard++;
            if (busy_cnt == 20) begin
                dif.Fill_Start = 1'b1;
                dif.Fill_Color = 9'h1FF;
            end else begin
                dif.Fill_Start = 1'b0;
                dif.Fill_Color = 9'h000;
            end
            if (!dif.Fill_Busy) break;
            busy_cnt++;
            if (!dif.Draw_Ready) rdy_low++;
        end
        check("fill_busy_cycles", 32'(busy_cnt), 32'd128);
        check("fill_ready_low_cycles", 32'(rdy_low), 32'd128);
        check("pending_draw_accepted", 32'(dif.Draw_Ready), 32'd1);
        @(negedge clk);
        dif.Draw_Valid = 1'b0;
        check("fill_restart_ignored", 32'(dif.Fill_Busy), 32'd0);
        for (int i = 0; i < DEPTH; i++) fb_model[i] = 9'h000;
        fb_model[3*FBW + 5] = 9'h1FF;

        // Second draw and out-of-range draws (accepted, not written)
        draw_px(6, 3, 9'b100_000_111, "draw_6_3");
        draw_px(16, 0, 9'h155, "draw_oor_x");
        draw_px(0, 8, 9'h155, "draw_oor_y");

        scan_frame("frame1");
        check("f1_px_20_12", 32'(p_20_12), 32'h00FFFFFF);
        check("f1_px_23_15", 32'(p_23_15), 32'h00FFFFFF);
        check("f1_px_24_12", 32'(p_24_12), 32'h009200FF);
        check("f1_px_27_15", 32'(p_27_15), 32'h009200FF);
        check("f1_px_19_12", 32'(p_19_12), 32'd0);
        check("f1_px_28_12", 32'(p_28_12), 32'd0);
        check("f1_px_4_12", 32'(p_4_12), 32'd0);

        // Reset during a fill after words 0..49 have been written
        @(negedge clk);
        dif.Fill_Color = 9'h0E9;
        dif.Fill_Start = 1'b1;
        @(negedge clk);
        dif.Fill_Start = 1'b0;
        repeat (50) @(negedge clk);
        check("midfill_busy", 32'(dif.Fill_Busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midfill_rst_busy", 32'(dif.Fill_Busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midfill_post_ready", 32'(dif.Draw_Ready), 32'd1);
        check("midfill_post_busy", 32'(dif.Fill_Busy), 32'd0);
        for (int i = 0; i < 50; i++) fb_model[i] = 9'h0E9;

        scan_frame("frame2");
        check("f2_px_4_12", 32'(p_4_12), 32'h006DB624);
        check("f2_px_8_12", 32'(p_8_12), 32'd0);
        check("f2_px_20_12", 32'(p_20_12), 32'h00FFFFFF);
        check("f2_px_24_12", 32'(p_24_12), 32'h009200FF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
